// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 PRGA decrypter.
// The ASCII bounds are only referenced when PRGA_ASCII_CHECK_EN is defined.
package rc4_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_GNT,
        RD_SI,
        WT_SI,
        RD_SJ,
        WT_SJ,
        WR_SI,
        WR_SJ,
        RD_F,
        WT_F,
        WR_DEC,
        NEXT,
        DONE
    } prga_state_t;

    localparam logic [7:0] ASCII_LO    = 8'h61;
    localparam logic [7:0] ASCII_HI    = 8'h7A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/ascii_check.sv
// Combinational test that a decrypted byte is a lowercase letter or a space.
// Only compiled when PRGA_ASCII_CHECK_EN is defined.
`ifdef PRGA_ASCII_CHECK_EN
module ascii_check
    import rc4_pkg::*;
(
    input  logic [7:0] i_byte,
    output logic       o_ok
);

    assign o_ok = ((i_byte >= ASCII_LO) && (i_byte <= ASCII_HI)) || (i_byte == ASCII_SPACE);

endmodule
`endif

// File: rtl/prga_decrypt.sv
// RC4 PRGA: decrypts MSG_LEN bytes using an S-box already filled by the KSA.
// Optional PRGA_ASCII_CHECK_EN adds msg_valid and stops on the first non-text byte.
module prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
)
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              s_req,
    input  logic              s_gnt,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        s_q,
    output logic [MSG_AW-1:0] enc_address,
    input  logic [7:0]        enc_q,
    output logic [MSG_AW-1:0] dec_address,
    output logic [7:0]        dec_data,
    output logic              dec_wren
`ifdef PRGA_ASCII_CHECK_EN
    ,
    output logic              msg_valid
`endif
);

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    prga_state_t       r_state;
    logic [7:0]        r_i;
    logic [7:0]        r_j;
    logic [MSG_AW-1:0] r_k;
    logic [7:0]        r_si;
    logic [7:0]        r_sj;
    logic [7:0]        r_f;
    logic [7:0]        r_e;

    // f and e are held for the whole WR_DEC cycle, so their XOR is stable there.
    assign dec_data = r_f ^ r_e;

`ifdef PRGA_ASCII_CHECK_EN
    logic w_ascii_ok;

    ascii_check u_ascii_check (
        .i_byte (s_q ^ enc_q),
        .o_ok   (w_ascii_ok)
    );
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_si        <= '0;
            r_sj        <= '0;
            r_f         <= '0;
            r_e         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            s_req       <= 1'b0;
            s_address   <= '0;
            s_data      <= '0;
            s_wren      <= 1'b0;
            enc_address <= '0;
            dec_address <= '0;
            dec_wren    <= 1'b0;
`ifdef PRGA_ASCII_CHECK_EN
            msg_valid   <= 1'b0;
`endif
        end else begin
            s_wren   <= 1'b0;
            dec_wren <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                        busy    <= 1'b1;
                        s_req   <= 1'b1;
`ifdef PRGA_ASCII_CHECK_EN
                        msg_valid <= 1'b0;
`endif
                        r_state <= WAIT_GNT;
                    end
                end
                WAIT_GNT: begin
                    if (s_gnt) begin
                        r_i       <= r_i + 8'd1;
                        s_address <= r_i + 8'd1;
                        r_state   <= RD_SI;
                    end
                end
                RD_SI: r_state <= WT_SI;
                WT_SI: begin
                    r_si      <= s_q;
                    r_j       <= r_j + s_q;
                    s_address <= r_j + s_q;
                    r_state   <= RD_SJ;
                end
                RD_SJ: r_state <= WT_SJ;
                WT_SJ: begin
                    // s_q is S[j]; it becomes the new S[i] on the way into WR_SI.
                    r_sj      <= s_q;
                    s_address <= r_i;
                    s_data    <= s_q;
                    s_wren    <= 1'b1;
                    r_state   <= WR_SI;
                end
                WR_SI: begin
                    s_address <= r_j;
                    s_data    <= r_si;
                    s_wren    <= 1'b1;
                    r_state   <= WR_SJ;
                end
                WR_SJ: begin
                    s_address   <= r_si + r_sj;
                    enc_address <= r_k;
                    r_state     <= RD_F;
                end
                RD_F: r_state <= WT_F;
                WT_F: begin
                    r_f <= s_q;
                    r_e <= enc_q;
`ifdef PRGA_ASCII_CHECK_EN
                    if (!w_ascii_ok) begin
                        busy    <= 1'b0;
                        s_req   <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else
`endif
                    begin
                        dec_address <= r_k;
                        dec_wren    <= 1'b1;
                        r_state     <= WR_DEC;
                    end
                end
                WR_DEC: r_state <= NEXT;
                NEXT: begin
                    if (r_k == K_LAST) begin
                        busy    <= 1'b0;
                        s_req   <= 1'b0;
                        done    <= 1'b1;
`ifdef PRGA_ASCII_CHECK_EN
                        msg_valid <= 1'b1;
`endif
                        r_state <= DONE;
                    end else begin
                        r_k       <= r_k + MSG_AW'(1);
                        r_i       <= r_i + 8'd1;
                        s_address <= r_i + 8'd1;
                        r_state   <= RD_SI;
                    end
                end
                DONE: begin
                    if (!start) begin
                        done    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prga_decrypt.sv
// Bench for prga_decrypt: RC4 reference model with write queues plus directed
// literal vectors; also builds cleanly with PRGA_ASCII_CHECK_EN defined.
module tb_prga_decrypt;

    localparam int LEN = 9;
    localparam int AW  = 5;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    int total = 0;
    int bad   = 0;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          s_gnt = 1'b0;
    logic          busy, done, s_req, s_wren, dec_wren;
    logic [7:0]    s_address, s_data, s_q, enc_q, dec_data;
    logic [AW-1:0] enc_address, dec_address;

    logic          start1 = 1'b0;
    logic          s_gnt1 = 1'b1;
    logic          busy1, done1, s_req1, s_wren1, dec_wren1;
    logic [7:0]    s_address1, s_data1, s_q1, enc_q1, dec_data1;
    logic [0:0]    enc_address1, dec_address1;

`ifdef PRGA_ASCII_CHECK_EN
    logic msg_valid, msg_valid1;
    logic exp_valid;
    // First byte lower-cased so the whole message passes the text check.
    logic [7:0] enc_lit   [LEN] = '{8'h9B, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] plain_lit [LEN] = '{8'h70, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
`else
    logic [7:0] enc_lit   [LEN] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] plain_lit [LEN] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
`endif

    always #5 clk = ~clk;

    prga_decrypt #(.MSG_LEN(LEN), .MSG_AW(AW)) u_dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .s_req(s_req), .s_gnt(s_gnt), .s_address(s_address), .s_data(s_data),
        .s_wren(s_wren), .s_q(s_q), .enc_address(enc_address), .enc_q(enc_q),
        .dec_address(dec_address), .dec_data(dec_data), .dec_wren(dec_wren)
`ifdef PRGA_ASCII_CHECK_EN
        , .msg_valid(msg_valid)
`endif
    );

    prga_decrypt #(.MSG_LEN(1), .MSG_AW(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .busy(busy1), .done(done1),
        .s_req(s_req1), .s_gnt(s_gnt1), .s_address(s_address1), .s_data(s_data1),
        .s_wren(s_wren1), .s_q(s_q1), .enc_address(enc_address1), .enc_q(enc_q1),
        .dec_address(dec_address1), .dec_data(dec_data1), .dec_wren(dec_wren1)
`ifdef PRGA_ASCII_CHECK_EN
        , .msg_valid(msg_valid1)
`endif
    );

    // Memory models: registered read, so q is valid in the wait state.
    logic [7:0] smem [256];
    logic [7:0] encm [32];
    logic [7:0] decm [32];
    logic [7:0] s_init [256];
    logic [7:0] enc_init [32];
    logic       ld_go = 1'b0;
    logic [7:0] smem1 [256];
    logic [7:0] encm1 [2];
    logic [7:0] decm1 [2];
    logic       ld1_go = 1'b0;

    always @(posedge clk) begin
        if (ld_go) begin
            for (int n = 0; n < 256; n++) smem[n] <= s_init[n];
            for (int n = 0; n < 32; n++) begin
                encm[n] <= enc_init[n];
                decm[n] <= 8'h00;
            end
        end else begin
            if (s_wren)   smem[s_address]   <= s_data;
            if (dec_wren) decm[dec_address] <= dec_data;
        end
        s_q   <= smem[s_address];
        enc_q <= encm[enc_address];
    end

    always @(posedge clk) begin
        if (ld1_go) begin
            for (int n = 0; n < 256; n++) smem1[n] <= 8'(n);
            encm1[0] <= 8'h63;
            encm1[1] <= 8'h00;
            decm1[0] <= 8'h00;
            decm1[1] <= 8'h00;
        end else begin
            if (s_wren1)   smem1[s_address1]   <= s_data1;
            if (dec_wren1) decm1[dec_address1] <= dec_data1;
        end
        s_q1   <= smem1[s_address1];
        enc_q1 <= encm1[enc_address1];
    end

    wr_t        exp_s [$];
    wr_t        exp_d [$];
    logic [7:0] model_dec [32];
    int         n_dec = 0;
    int         n_sw1 = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ksa_key();
        logic [7:0] key [3];
        int j, t;
        key = '{8'h4B, 8'h65, 8'h79};
        for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
        j = 0;
        for (int n = 0; n < 256; n++) begin
            j = (j + s_init[n] + key[n % 3]) % 256;
            t = s_init[n];
            s_init[n] = s_init[j];
            s_init[j] = 8'(t);
        end
    endtask

    // Plain-arithmetic RC4 PRGA producing the expected S and dec write streams.
    task automatic model_run(input int len);
        int  S [256];
        int  i, j, t, p;
        wr_t w;
        exp_s.delete();
        exp_d.delete();
`ifdef PRGA_ASCII_CHECK_EN
        exp_valid = 1'b1;
`endif
        for (int n = 0; n < 256; n++) S[n] = s_init[n];
        i = 0;
        j = 0;
        for (int k = 0; k < len; k++) begin
            i = (i + 1) % 256;
            j = (j + S[i]) % 256;
            w.a = 8'(i); w.d = 8'(S[j]); exp_s.push_back(w);
            w.a = 8'(j); w.d = 8'(S[i]); exp_s.push_back(w);
            t = S[i]; S[i] = S[j]; S[j] = t;
            p = S[(S[i] + S[j]) % 256] ^ enc_init[k];
            model_dec[k] = 8'(p);
`ifdef PRGA_ASCII_CHECK_EN
            if (!((p >= 97 && p <= 122) || p == 32)) begin
                exp_valid = 1'b0;
                return;
            end
`endif
            w.a = 8'(k); w.d = 8'(p); exp_d.push_back(w);
        end
    endtask

    task automatic load();
        ld_go = 1'b1;
        @(posedge clk); #1;
        ld_go = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while (!done && c < 400) begin
            @(posedge clk); #1;
            c++;
        end
        chk(name, int'(done), 1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_s_req"}, int'(s_req), 0);
        chk({tag, "_s_wren"}, int'(s_wren), 0);
        chk({tag, "_dec_wren"}, int'(dec_wren), 0);
        chk({tag, "_s_address"}, int'(s_address), 0);
        chk({tag, "_s_data"}, int'(s_data), 0);
        chk({tag, "_enc_address"}, int'(enc_address), 0);
        chk({tag, "_dec_address"}, int'(dec_address), 0);
        chk({tag, "_dec_data"}, int'(dec_data), 0);
`ifdef PRGA_ASCII_CHECK_EN
        chk({tag, "_msg_valid"}, int'(msg_valid), 0);
`endif
    endtask

    task automatic chk_plain(input string tag);
        for (int k = 0; k < LEN; k++) chk({tag, "_dec_ram"}, int'(decm[k]), int'(plain_lit[k]));
        chk({tag, "_exp_s_left"}, exp_s.size(), 0);
        chk({tag, "_exp_d_left"}, exp_d.size(), 0);
`ifdef PRGA_ASCII_CHECK_EN
        chk({tag, "_msg_valid"}, int'(msg_valid), 1);
`endif
    endtask

    task automatic set_enc_lit();
        for (int k = 0; k < 32; k++) enc_init[k] = (k < LEN) ? enc_lit[k] : 8'h00;
    endtask

    // Per-cycle compare of every memory write against the model queues.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (reset_n && !ld_go) begin
                chk("s_req_eq_busy", int'(s_req), int'(busy));
                if (s_wren) begin
                    $display("s write  addr=%02h data=%02h", s_address, s_data);
                    if (exp_s.size() == 0) chk("s_write_unexpected", 1, 0);
                    else begin
                        e = exp_s.pop_front();
                        chk("s_wr_addr", int'(s_address), int'(e.a));
                        chk("s_wr_data", int'(s_data), int'(e.d));
                    end
                end
                if (dec_wren) begin
                    $display("dec write addr=%0d data=%02h", dec_address, dec_data);
                    n_dec++;
                    if (exp_d.size() == 0) chk("dec_write_unexpected", 1, 0);
                    else begin
                        e = exp_d.pop_front();
                        chk("dec_wr_addr", int'(dec_address), int'(e.a));
                        chk("dec_wr_data", int'(dec_data), int'(e.d));
                    end
                end
                if (s_wren1) begin
                    $display("s1 write addr=%02h data=%02h", s_address1, s_data1);
                    n_sw1++;
                    chk("id_s_wr_addr", int'(s_address1), 1);
                    chk("id_s_wr_data", int'(s_data1), 1);
                end
                if (dec_wren1) begin
                    $display("dec1 write addr=%0d data=%02h", dec_address1, dec_data1);
                    chk("id_dec_addr", int'(dec_address1), 0);
                    chk("id_dec_data", int'(dec_data1), 8'h61);
                end
            end
        end
    end

    initial begin
        int  c;
        int  found;
        int  mism;
        logic prev;
        logic [7:0] want [LEN];

        ksa_key();
        set_enc_lit();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer run; start toggled mid-run and held high through DONE.
        load();
        model_run(LEN);
        for (int k = 0; k < LEN; k++) chk("model_pin", int'(model_dec[k]), int'(plain_lit[k]));
        s_gnt = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        chk("start_busy", int'(busy), 1);
        repeat (15) @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        wait_done("kat_done");
        chk_plain("kat");
        repeat (5) begin
            @(posedge clk); #1;
            chk("hold_done", int'(done), 1);
            chk("hold_not_busy", int'(busy), 0);
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk("idle_done", int'(done), 0);
        chk("idle_busy", int'(busy), 0);

        // Grant withheld for 20 cycles.
        load();
        model_run(LEN);
        s_gnt = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
`ifdef PRGA_ASCII_CHECK_EN
        chk("valid_cleared_on_start", int'(msg_valid), 0);
`endif
        for (int n = 0; n < 20; n++) begin
            chk("gnt_wait_s_req", int'(s_req), 1);
            chk("gnt_wait_no_wr", int'(s_wren), 0);
            @(posedge clk); #1;
        end
        s_gnt = 1'b1;
        @(posedge clk); #1;
        chk("gnt_progress_addr", int'(s_address), 1);
        wait_done("gnt_done");
        chk_plain("gnt");
        start = 1'b0;
        @(posedge clk); #1;

        // Reset pulsed in WR_SJ of byte 3, then a fresh run from k=0.
        load();
        model_run(LEN);
        n_dec = 0;
        start = 1'b1;
        prev  = 1'b0;
        found = 0;
        for (c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            if (s_wren && prev && n_dec == 3) begin
                found = 1;
                break;
            end
            prev = s_wren;
        end
        chk("found_wr_sj", found, 1);
        #1 reset_n = 1'b0;
        #1 chk_zero("midrun_reset");
        start = 1'b0;
        for (int k = 0; k < 3; k++) chk("kept_dec", int'(decm[k]), int'(plain_lit[k]));
        chk("dec3_unwritten", int'(decm[3]), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        load();
        model_run(LEN);
        n_dec = 0;
        start = 1'b1;
        wait_done("rerun_done");
        chk_plain("rerun");
        chk("rerun_n_dec", n_dec, LEN);
        start = 1'b0;
        @(posedge clk); #1;

        // Identity S-box, single byte: i=j=1, S unchanged, dec = enc ^ S[2].
        ld1_go = 1'b1;
        @(posedge clk); #1;
        ld1_go = 1'b0;
        start1 = 1'b1;
        c = 0;
        while (!done1 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("id_done", int'(done1), 1);
        chk("id_dec0", int'(decm1[0]), 8'h61);
        chk("id_n_swrites", n_sw1, 2);
        mism = 0;
        for (int n = 0; n < 256; n++) if (smem1[n] != 8'(n)) mism++;
        chk("id_s_unchanged", mism, 0);
`ifdef PRGA_ASCII_CHECK_EN
        chk("id_msg_valid", int'(msg_valid1), 1);
`endif
        start1 = 1'b0;
        @(posedge clk); #1;

`ifdef PRGA_ASCII_CHECK_EN
        // Byte 2 decrypts to 'A': stop before writing it.
        for (int k = 0; k < LEN; k++) want[k] = (k == 2) ? 8'h41 : ((k == 1) ? 8'h62 : 8'h61);
        for (int k = 0; k < LEN; k++) enc_init[k] = enc_lit[k] ^ plain_lit[k] ^ want[k];
        load();
        model_run(LEN);
        n_dec = 0;
        start = 1'b1;
        wait_done("ascii_bad_done");
        chk("ascii_bad_valid", int'(msg_valid), 0);
        chk("ascii_bad_model_valid", int'(msg_valid), int'(exp_valid));
        chk("ascii_bad_dec0", int'(decm[0]), 8'h61);
        chk("ascii_bad_dec1", int'(decm[1]), 8'h62);
        chk("ascii_bad_dec2", int'(decm[2]), 8'h00);
        chk("ascii_bad_n_dec", n_dec, 2);
        chk("ascii_bad_exp_s_left", exp_s.size(), 0);
        start = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < LEN; k++) enc_init[k] = enc_lit[k] ^ plain_lit[k] ^ 8'h61;
        load();
        model_run(LEN);
        start = 1'b1;
        wait_done("ascii_ok_done");
        chk("ascii_ok_valid", int'(msg_valid), 1);
        for (int k = 0; k < LEN; k++) chk("ascii_ok_dec", int'(decm[k]), 8'h61);
        start = 1'b0;
        @(posedge clk); #1;
`else
        for (int k = 0; k < LEN; k++) want[k] = 8'h00;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prga_decrypt.md
PRGA_DECRYPT -- requirements
Module: prga_decrypt

Interface
REQ-001 SHALL have parameter MSG_LEN, default 32, giving the number of message bytes decrypted per run.
REQ-002 SHALL have parameter MSG_AW, default 5, giving the width of the message ROM/RAM address (2^MSG_AW >= MSG_LEN).
REQ-003 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 SHALL have port reset_n, input, 1, an asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a level request to begin decryption; it is sampled only in IDLE.
REQ-006 SHALL have port busy, output, 1, high in every state except IDLE and DONE.
REQ-007 SHALL have port done, output, 1, high in DONE.
REQ-008 SHALL have port s_req, output, 1, requesting S-memory ownership from the memory handler.
REQ-009 SHALL have port s_gnt, input, 1, the S-memory grant.
REQ-010 SHALL have S-memory ports s_address out 8, s_data out 8, s_wren out 1 and s_q in 8.
REQ-011 SHALL have encrypted-ROM ports enc_address out MSG_AW and enc_q in 8.
REQ-012 SHALL have decrypted-RAM ports dec_address out MSG_AW, dec_data out 8 and dec_wren out 1.

Function
REQ-013 SHALL implement the RC4 PRGA over an S-box already filled by the KSA: i=j=0; for k=0..MSG_LEN-1: i=i+1; j=j+S[i]; swap S[i],S[j]; dec[k]=S[S[i]+S[j]] XOR enc[k].
REQ-014 SHALL perform all i, j and S[i]+S[j] arithmetic as 8-bit modulo-256 (i wraps 255->0).
REQ-015 SHALL treat every memory as returning q valid on the second rising edge after the address is driven, with one wait state per read.
REQ-016 SHALL use states IDLE, WAIT_GNT, RD_SI, WT_SI, RD_SJ, WT_SJ, WR_SI, WR_SJ, RD_F, WT_F, WR_DEC, NEXT and DONE.
REQ-017 SHALL transition IDLE->WAIT_GNT on start, with i, j and k cleared to 0.
REQ-018 SHALL assert s_req from WAIT_GNT through NEXT, and SHALL move WAIT_GNT->RD_SI only when s_gnt=1.
REQ-019 SHALL increment i in RD_SI, capture si=s_q in WT_SI, and set j=j+si at the same time.
REQ-020 SHALL capture sj=s_q in WT_SJ.
REQ-021 SHALL write s_data=sj at s_address=i in WR_SI, and s_data=si at s_address=j in WR_SJ, with s_wren=1 for exactly one cycle each.
REQ-022 SHALL, when i==j, still perform both writes, leaving S[i] unchanged.
REQ-023 SHALL drive s_address=si+sj and enc_address=k in RD_F, and capture f=s_q and e=enc_q in WT_F.
REQ-024 SHALL drive dec_address=k, dec_data=f^e and dec_wren=1 for one cycle in WR_DEC.
REQ-025 SHALL go NEXT->DONE when k==MSG_LEN-1; otherwise it SHALL increment k and go to RD_SI.
REQ-026 SHALL drop s_req in DONE, hold done=1 while start=1, and return to IDLE when start=0.
REQ-027 SHALL ignore start while busy.
REQ-028 SHALL keep s_wren and dec_wren at 0 in every state not listed above.
REQ-029 SHALL require s_gnt to stay high while s_req=1; behaviour on a dropped grant is outside this spec.

Reset
REQ-030 SHALL, on reset_n=0 at any time including mid-run, go immediately to IDLE and clear i, j, k, si, sj, f, e and all outputs to 0.
REQ-031 SHALL NOT roll back S-memory or decrypted-RAM contents when reset interrupts a run.

Configuration
REQ-032 SHALL, with PRGA_ASCII_CHECK_EN defined, add output msg_valid (1 bit, cleared on start acceptance and reset) and check every dec_data byte for 0x61-0x7A or 0x20.
REQ-033 SHALL, with PRGA_ASCII_CHECK_EN defined, on the first failing byte suppress its dec_wren, leave msg_valid=0 and go directly to DONE; msg_valid SHALL go 1 on entering DONE after all bytes pass.
REQ-034 SHALL, without PRGA_ASCII_CHECK_EN, have no msg_valid port, and every byte SHALL be written.

Structure
REQ-035 SHALL place the state enum typedef and the ASCII bounds constants (0x61, 0x7A, 0x20) in the shared package rc4_pkg.
REQ-036 SHALL factor the ASCII range check into a combinational sub-module named ascii_check, instantiated only under PRGA_ASCII_CHECK_EN.

Verification
REQ-037 SHALL verify: S preloaded with KSA("Key"), enc = BB F3 16 E8 D9 40 AF 0A D3, MSG_LEN=9 -> dec = "Plaintext" (50 6C 61 69 6E 74 65 78 74) and done=1.
REQ-038 SHALL verify: identity S (S[n]=n), MSG_LEN=1 -> i=1, j=1, S unchanged, dec[0] = enc[0]^S[2] = enc[0]^0x02.
REQ-039 SHALL verify: s_gnt held 0 for 20 cycles after start -> s_req=1, no memory writes, and progress begins the cycle after s_gnt=1.
REQ-040 SHALL verify: reset_n pulsed low in WR_SJ of byte 3 -> all outputs 0 immediately, and the next start reruns from k=0.
REQ-041 SHALL verify, with PRGA_ASCII_CHECK_EN: enc chosen so dec[2]=0x41 -> dec[0..1] written, dec[2] not written, DONE with msg_valid=0; an all-'a' result -> msg_valid=1.
REQ-042 SHALL verify: start asserted again while busy and while done=1 -> no restart until start=0 and a fresh start arrives in IDLE.
